// File: rtl/instruction_decoder.sv
// Fetch/decode stage of the MC14500B-style 1-bit processor: issues opcode/operand,
// applies SKZ/RTN skip rules, drives the counter jump strobe. Optional skip counter: IFD_SKIP_CNT_EN.
module instruction_decoder #(
    parameter int SIZE_LOG   = 8,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] instr_in,
    input  logic                  rr_in,
    output logic                  op_valid,
    output logic [3:0]            opcode,
    output logic [WORD_WIDTH-5:0] operand,
    output logic                  flag_o,
    output logic                  flag_f,
    output logic                  rtn,
    output logic                  pc_write,
    output logic [SIZE_LOG-1:0]   pc_address
`ifdef IFD_SKIP_CNT_EN
    ,
    output logic [15:0]           skip_count
`endif
);

    // state  | meaning
    // FETCH  | decode/issue (or suppress) the current program word
    // TARGET | current word is a JMP target; load it into the counter
    // SKIP   | current word is the target of a suppressed JMP; discard it
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_TARGET = 2'd1,
        ST_SKIP   = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    state_t                state;
    logic                  skz_pend;
    logic                  skip_next;
    logic [3:0]            word_opc;
    logic [WORD_WIDTH-5:0] word_opd;
    logic                  skip_now;

    assign word_opc = instr_in[WORD_WIDTH-1 -: 4];
    assign word_opd = instr_in[WORD_WIDTH-5:0];
    // rr_in is looked at on the word after SKZ, so it reflects everything issued before SKZ
    assign skip_now = skip_next | (skz_pend & ~rr_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            skz_pend   <= 1'b0;
            skip_next  <= 1'b0;
            op_valid   <= 1'b0;
            opcode     <= '0;
            operand    <= '0;
            flag_o     <= 1'b0;
            flag_f     <= 1'b0;
            rtn        <= 1'b0;
            pc_write   <= 1'b0;
            pc_address <= '0;
        end else begin
            op_valid <= 1'b0;
            flag_o   <= 1'b0;
            flag_f   <= 1'b0;
            rtn      <= 1'b0;
            pc_write <= 1'b0;
            case (state)
                ST_FETCH: begin
                    skz_pend  <= 1'b0;
                    skip_next <= 1'b0;
                    if (skip_now) begin
                        // a suppressed JMP drags its target word along with it
                        if (word_opc == OP_JMP)
                            state <= ST_SKIP;
                    end else begin
                        op_valid <= 1'b1;
                        opcode   <= word_opc;
                        operand  <= word_opd;
                        case (word_opc)
                            OP_NOPO: flag_o <= 1'b1;
                            OP_NOPF: flag_f <= 1'b1;
                            OP_RTN: begin
                                rtn       <= 1'b1;
                                skip_next <= 1'b1;
                            end
                            OP_SKZ:  skz_pend <= 1'b1;
                            OP_JMP:  state    <= ST_TARGET;
                            default: ;
                        endcase
                    end
                end
                ST_TARGET: begin
                    pc_address <= instr_in[SIZE_LOG-1:0];
                    pc_write   <= 1'b1;
                    state      <= ST_FETCH;
                end
                ST_SKIP: begin
                    state <= ST_FETCH;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef IFD_SKIP_CNT_EN
    logic suppressed;

    assign suppressed = ((state == ST_FETCH) && skip_now) || (state == ST_SKIP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_count <= '0;
        else if (suppressed && (skip_count != 16'hFFFF))
            skip_count <= skip_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: expected output records are queued as each
// word is driven and compared after the posedge that samples it.
module tb_instruction_decoder;

    typedef struct packed {
        logic       v;
        logic [3:0] opc;
        logic [3:0] opd;
        logic       fo;
        logic       ff;
        logic       rt;
        logic       pw;
        logic [7:0] pa;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr_in = 8'h00;
    logic       rr_in = 1'b0;
    logic       op_valid;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       flag_o;
    logic       flag_f;
    logic       rtn;
    logic       pc_write;
    logic [7:0] pc_address;
`ifdef IFD_SKIP_CNT_EN
    logic [15:0] skip_count;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instruction_decoder #(.SIZE_LOG(8), .WORD_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .rr_in      (rr_in),
        .op_valid   (op_valid),
        .opcode     (opcode),
        .operand    (operand),
        .flag_o     (flag_o),
        .flag_f     (flag_f),
        .rtn        (rtn),
        .pc_write   (pc_write),
        .pc_address (pc_address)
`ifdef IFD_SKIP_CNT_EN
        ,
        .skip_count (skip_count)
`endif
    );

    function automatic exp_t observed();
        return {op_valid, opcode, operand, flag_o, flag_f, rtn, pc_write, pc_address};
    endfunction

    // Drive one word, queue what the outputs must show after the sampling posedge, then compare.
    task automatic step(input string tag, input logic [7:0] w, input logic rr,
                        input logic v, input logic [3:0] opc, input logic [3:0] opd,
                        input logic fo, input logic ff, input logic rt,
                        input logic pw, input logic [7:0] pa);
        exp_t e;
        exp_t got;
        e = {v, opc, opd, fo, ff, rt, pw, pa};
        instr_in = w;
        rr_in    = rr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = observed();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty, got=%h", tag, got);
        end else begin
            e = sb.pop_front();
            assert (got === e) else begin
                failures++;
                $error("FAIL %s got=%h expected=%h", tag, got, e);
            end
        end
    endtask

    task automatic check_count(input string tag, input logic [15:0] want);
`ifdef IFD_SKIP_CNT_EN
        checks++;
        assert (skip_count === want) else begin
            failures++;
            $error("FAIL %s skip_count got=%0d expected=%0d", tag, skip_count, want);
        end
`else
        if (want == 16'hFFFF) $display("unused %s", tag);
`endif
    endtask

    initial begin
        exp_t got;
        repeat (2) @(posedge clk);
        #1;
        got = observed();
        checks++;
        assert (got === exp_t'(0)) else begin
            failures++;
            $error("FAIL reset_values got=%h expected=%h", got, exp_t'(0));
        end
        check_count("reset_count", 16'd0);
        @(negedge clk);
        rst = 1'b0;

        //     tag            word   rr   v  opc   opd   fo ff rt pw pa
        step("ld",           8'h15, 0, 1, 4'h1, 4'h5, 0, 0, 0, 0, 8'h00);
        step("jmp_issue",    8'hC0, 0, 1, 4'hC, 4'h0, 0, 0, 0, 0, 8'h00);
        step("jmp_target",   8'h40, 0, 0, 4'hC, 4'h0, 0, 0, 0, 1, 8'h40);
        step("after_jmp",    8'h21, 0, 1, 4'h2, 4'h1, 0, 0, 0, 0, 8'h40);

        step("skz_taken",    8'hE0, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skz_skipped",  8'h83, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skz_resume",   8'h35, 1, 1, 4'h3, 4'h5, 0, 0, 0, 0, 8'h40);
        check_count("count_skz", 16'd1);

        step("skz_nt",       8'hE0, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skz_nt_sto",   8'h83, 1, 1, 4'h8, 4'h3, 0, 0, 0, 0, 8'h40);

        step("skz_jmp",      8'hE0, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skipped_jmp",  8'hC0, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skipped_tgt",  8'h10, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("after_skjmp",  8'h46, 0, 1, 4'h4, 4'h6, 0, 0, 0, 0, 8'h40);
        check_count("count_skjmp", 16'd3);

        step("rtn",          8'hD0, 0, 1, 4'hD, 4'h0, 0, 0, 1, 0, 8'h40);
        step("rtn_skip_f",   8'hF0, 0, 0, 4'hD, 4'h0, 0, 0, 0, 0, 8'h40);
        step("nopo_1",       8'h00, 0, 1, 4'h0, 4'h0, 1, 0, 0, 0, 8'h40);
        step("nopo_2",       8'h00, 0, 1, 4'h0, 4'h0, 1, 0, 0, 0, 8'h40);
        step("nopf",         8'hF7, 0, 1, 4'hF, 4'h7, 0, 1, 0, 0, 8'h40);
        check_count("count_rtn", 16'd4);

        // a suppressed SKZ must not arm a skip
        step("rtn2",         8'hD0, 0, 1, 4'hD, 4'h0, 0, 0, 1, 0, 8'h40);
        step("skipped_skz",  8'hE0, 0, 0, 4'hD, 4'h0, 0, 0, 0, 0, 8'h40);
        step("no_pend_skz",  8'h83, 0, 1, 4'h8, 4'h3, 0, 0, 0, 0, 8'h40);

        // a suppressed RTN must not arm a skip
        step("skz_rtn",      8'hE0, 0, 1, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("skipped_rtn",  8'hD0, 0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 8'h40);
        step("no_pend_rtn",  8'h91, 0, 1, 4'h9, 4'h1, 0, 0, 0, 0, 8'h40);
        check_count("count_final", 16'd6);

        // reset in the middle of a jump: target never loads
        step("jmp_pre_rst",  8'hC0, 0, 1, 4'hC, 4'h0, 0, 0, 0, 0, 8'h40);
        instr_in = 8'h77;
        rst = 1'b1;
        #1;
        got = observed();
        checks++;
        assert (got === exp_t'(0)) else begin
            failures++;
            $error("FAIL async_reset got=%h expected=%h", got, exp_t'(0));
        end
        check_count("count_rst", 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_ld",  8'h15, 0, 1, 4'h1, 4'h5, 0, 0, 0, 0, 8'h00);
        step("post_rst_sto", 8'h83, 0, 1, 4'h8, 4'h3, 0, 0, 0, 0, 8'h00);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Fetch/decode stage of the MC14500B-style 1-bit processor. It sits directly downstream of the program counter, alongside the program ROM:
- It samples the program word addressed by the counter and splits it into opcode and I/O operand for the logic unit.
- It applies SKZ/RTN skip rules.
- It closes the loop back to the counter by producing the jump write strobe and target address.

## Interface
Parameters:
- SIZE_LOG, 8, program address width; must match the program counter; SIZE_LOG <= WORD_WIDTH.
- WORD_WIDTH, 8, program word width; opcode = word[WORD_WIDTH-1 -: 4], operand = word[WORD_WIDTH-5:0].

Ports:
- clk  in  1  system clock; this block acts on posedge, the counter on negedge.
- rst  in  1  asynchronous, active-high reset.
- instr_in  in  WORD_WIDTH  program ROM data for the current counter address.
- rr_in  in  1  result register from the logic unit.
- op_valid  out  1  opcode/operand hold an instruction to execute this cycle.
- opcode  out  4  decoded opcode.
- operand  out  WORD_WIDTH-4  I/O address field.
- flag_o  out  1  one-cycle pulse on an executed NOPO (0x0).
- flag_f  out  1  one-cycle pulse on an executed NOPF (0xF).
- rtn  out  1  one-cycle pulse on an executed RTN (0xD).
- pc_write  out  1  to counter write.
- pc_address  out  SIZE_LOG  to counter address_in.

## Operation
- Opcodes: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
- JMP is two words: the JMP word, then a target word; target = instr_in[SIZE_LOG-1:0].
- States:
  - FETCH
    - Decode instr_in and register the outputs.
    - JMP: issue it (op_valid=1, opcode=C), then go to TARGET.
    - SKZ: set skz_pend.
    - RTN: set skip_next.
  - TARGET
    - Capture the target into pc_address and set pc_write=1.
    - op_valid=0; go to FETCH.
  - SKIP
    - Ignore the word: op_valid=0, no flags.
    - If the word is JMP, stay in SKIP one more word (its target is skipped too); else go to FETCH.
- Skip decision, on entering each FETCH word:
  - skip_next=1 → treat the word as SKIP.
  - skz_pend=1 and rr_in=0 → treat the word as SKIP.
  - skz_pend=1 and rr_in=1 → execute the word normally.
  - Both flags clear once used.
- SKZ samples rr_in at the posedge after SKZ was decoded, so RR reflects every instruction issued before SKZ.
- A skipped SKZ or RTN has no effect (sets no pending skip).
- Output rules:
  - All outputs are registered.
  - opcode/operand hold their last value when op_valid=0.
  - Pulses (flag_o, flag_f, rtn, pc_write) last exactly one clk cycle.

## Timing
- Reset values:
  - State FETCH, skz_pend=0, skip_next=0.
  - op_valid=0, opcode=0, operand=0, flag_o=0, flag_f=0, rtn=0, pc_write=0, pc_address=0.
- Reset is asserted asynchronously and released synchronously to clk. Reset mid-JMP or mid-skip abandons the operation.
- Issue latency: a word sampled at posedge N is on the outputs after posedge N, valid until posedge N+1.
- Jump sequence:
  - JMP sampled at posedge N; the counter advances at the following negedge.
  - Target sampled at posedge N+1; pc_write is high from N+1 to N+2, so the counter loads the target at the negedge in between.
  - instr_in = ROM[target] at posedge N+2.
  - No flush cycle is needed.
- Throughput: one word per clk; JMP costs 2 cycles; a skipped JMP consumes 2 words.

## Configuration
- IFD_SKIP_CNT_EN defined:
  - Adds output skip_count [15:0], a saturating count (stops at 0xFFFF) of words suppressed in SKIP.
  - Cleared by rst.
- IFD_SKIP_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset: assert rst mid-TARGET → all outputs 0 immediately; after release, word 0x15 issues op_valid=1, opcode=1, operand=5 one cycle later.
- Jump: words 0xC0, 0x40 → JMP issued, pc_write=1 with pc_address=0x40 for exactly one cycle, next sampled word is ROM[0x40].
- SKZ taken: 0xE0 with rr_in=0 at the following posedge, then 0x83 → the 0x83 word has op_valid=0; the word after it executes.
- SKZ not taken / skipped JMP: 0xE0 with rr_in=1, then 0x83 → STO issued. 0xE0 with rr_in=0, then 0xC0, 0x10 → both words suppressed, pc_write stays 0.
- RTN and flags: 0xD0, 0xF0, 0x00, 0x00 → rtn pulse; the 0xF0 word is suppressed (no flag_f); the first 0x00 gives a flag_o pulse. With IFD_SKIP_CNT_EN, skip_count=1.
